// File: rtl/vec_cache_rd_req_xbar_nxm.sv
// N-requester to M-bank read-request crossbar: per-bank round-robin arbiter feeding a
// D-deep FIFO whose entries carry the payload plus the source requester index.
module vec_cache_rd_req_xbar_nxm #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int D       = 4,
  parameter int ADDR_W  = 64,
  parameter int PLD_W   = 128,
  parameter int SEL_LSB = 62,
  parameter int HASH_EN = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  in_vld,
  input  logic [N*ADDR_W-1:0]           in_addr,
  input  logic [N*PLD_W-1:0]            in_pld,
  output logic [N-1:0]                  in_rdy,
  output logic [M-1:0]                  out_vld,
  output logic [M*PLD_W-1:0]            out_pld,
  output logic [M*$clog2(N)-1:0]        out_src,
  input  logic [M-1:0]                  out_rdy,
  output logic [M*($clog2(D)+1)-1:0]    out_cnt
);
  localparam int SW = $clog2(M);
  localparam int NW = $clog2(N);
  localparam int DW = $clog2(D);
  localparam int CW = DW + 1;
  localparam int EW = PLD_W + NW;

  logic [N-1:0][SW-1:0] sel_s;
  logic [M-1:0][NW-1:0] ptr_r;
  logic [M-1:0][DW-1:0] wr_r;
  logic [M-1:0][DW-1:0] rd_r;
  logic [M-1:0][CW-1:0] cnt_r;
  logic [EW-1:0]        mem_r [M][D];
  logic [M-1:0]         gnt_s;
  logic [M-1:0]         pop_s;
  logic [M-1:0][NW-1:0] gidx_s;
  logic                 addr_unused_s;

  assign addr_unused_s = ^in_addr;

  for (genvar i = 0; i < N; i++) begin : g_sel
    if (HASH_EN != 0) begin : g_hash
      assign sel_s[i] = in_addr[i*ADDR_W+SEL_LSB +: SW] ^ in_addr[i*ADDR_W+SEL_LSB-SW +: SW];
    end else begin : g_plain
      assign sel_s[i] = in_addr[i*ADDR_W+SEL_LSB +: SW];
    end
  end

  // Round-robin search per bank, starting at ptr and wrapping; blocked when the bank has no space
  always_comb begin
    logic [NW-1:0] idx;
    logic          hit;
    logic          space;
    gnt_s  = '0;
    gidx_s = '0;
    pop_s  = '0;
    idx    = '0;
    hit    = 1'b0;
    space  = 1'b0;
    for (int j = 0; j < M; j++) begin
      pop_s[j] = (cnt_r[j] != {CW{1'b0}}) && out_rdy[j];
      space    = (cnt_r[j] < CW'(D)) || out_rdy[j];
      for (int k = 0; k < N; k++) begin
        idx       = ((int'(ptr_r[j]) + k) >= N) ? NW'(int'(ptr_r[j]) + k - N) : NW'(int'(ptr_r[j]) + k);
        hit       = space && in_vld[idx] && (sel_s[idx] == SW'(j));
        gidx_s[j] = (hit && !gnt_s[j]) ? idx : gidx_s[j];
        gnt_s[j]  = gnt_s[j] | hit;
      end
    end
  end

  // A requester is ready when the bank it targets granted it
  always_comb begin
    in_rdy = '0;
    for (int i = 0; i < N; i++) begin
      in_rdy[i] = !rst && gnt_s[sel_s[i]] && (gidx_s[sel_s[i]] == NW'(i));
    end
  end

  // Arbiter pointers, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
      wr_r  <= '0;
      rd_r  <= '0;
      cnt_r <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        if (gnt_s[j]) begin
          ptr_r[j] <= (gidx_s[j] == NW'(N-1)) ? {NW{1'b0}} : gidx_s[j] + NW'(1);
          wr_r[j]  <= wr_r[j] + DW'(1);
        end
        if (pop_s[j]) begin
          rd_r[j] <= rd_r[j] + DW'(1);
        end
        case ({gnt_s[j], pop_s[j]})
          2'b10:   cnt_r[j] <= cnt_r[j] + CW'(1);
          2'b01:   cnt_r[j] <= cnt_r[j] - CW'(1);
          default: cnt_r[j] <= cnt_r[j];
        endcase
      end
    end
  end

  // Entry storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < M; j++) begin
      if (gnt_s[j] && !rst) begin
        mem_r[j][wr_r[j]] <= {in_pld[gidx_s[j]*PLD_W +: PLD_W], gidx_s[j]};
      end
    end
  end

  // Outputs come only from registered FIFO state, so there is no request-to-output bypass
  always_comb begin
    out_vld = '0;
    out_pld = '0;
    out_src = '0;
    out_cnt = '0;
    for (int j = 0; j < M; j++) begin
      out_vld[j] = (cnt_r[j] != {CW{1'b0}});
      {out_pld[j*PLD_W +: PLD_W], out_src[j*NW +: NW]} = mem_r[j][rd_r[j]];
      out_cnt[j*CW +: CW] = cnt_r[j];
    end
  end

  vec_cache_rd_req_xbar_nxm_chk #(.N(N), .M(M), .D(D)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .in_rdy  (in_rdy),
    .sel     (sel_s),
    .gnt     (gnt_s),
    .out_rdy (out_rdy),
    .cnt     (cnt_r)
  );
endmodule

module vec_cache_rd_req_xbar_nxm_chk #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int D = 4
) (
  input logic                            clk,
  input logic                            rst,
  input logic [N-1:0]                    in_rdy,
  input logic [N*$clog2(M)-1:0]          sel,
  input logic [M-1:0]                    gnt,
  input logic [M-1:0]                    out_rdy,
  input logic [M*($clog2(D)+1)-1:0]      cnt
);
  localparam int SW = $clog2(M);
  localparam int CW = $clog2(D) + 1;

  function automatic logic [N-1:0] bank_mask(input logic [N*SW-1:0] s, input int j);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (s[i*SW +: SW] == SW'(j));
    end
    return m;
  endfunction

  // Occupancy bound, no overflowing push, single grant per bank
  always @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < M; j++) begin
        assert (cnt[j*CW +: CW] <= CW'(D)) else $error("bank %0d occupancy above depth", j);
        assert (!(gnt[j] && (cnt[j*CW +: CW] == CW'(D)) && !out_rdy[j]))
          else $error("bank %0d push into full fifo", j);
        assert ($countones(in_rdy & bank_mask(sel, j)) <= 1)
          else $error("bank %0d granted more than one requester", j);
      end
    end
  end
endmodule

// File: tb/tb_vec_cache_rd_req_xbar_nxm.sv
// Scoreboard bench for vec_cache_rd_req_xbar_nxm: a plain-select instance and a hashed-select
// instance; expected outputs are queued per bank at issue and popped by per-instance monitors.
module tb_vec_cache_rd_req_xbar_nxm;
  localparam int N = 8, M = 4, D = 4, AW = 64, PW = 128, NW = 3, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     in_vld, in_rdy, hb_in_vld, hb_in_rdy;
  logic [N*AW-1:0]  in_addr, hb_in_addr;
  logic [N*PW-1:0]  in_pld, hb_in_pld;
  logic [M-1:0]     out_vld, out_rdy, hb_out_vld, hb_out_rdy;
  logic [M*PW-1:0]  out_pld, hb_out_pld;
  logic [M*NW-1:0]  out_src, hb_out_src;
  logic [M*CW-1:0]  out_cnt, hb_out_cnt;

  vec_cache_rd_req_xbar_nxm #(.N(N), .M(M), .D(D), .ADDR_W(AW), .PLD_W(PW), .SEL_LSB(62), .HASH_EN(0)) u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_addr(in_addr), .in_pld(in_pld), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_pld(out_pld), .out_src(out_src), .out_rdy(out_rdy), .out_cnt(out_cnt));

  vec_cache_rd_req_xbar_nxm #(.N(N), .M(M), .D(D), .ADDR_W(AW), .PLD_W(PW), .SEL_LSB(62), .HASH_EN(1)) u_hash (
    .clk(clk), .rst(rst), .in_vld(hb_in_vld), .in_addr(hb_in_addr), .in_pld(hb_in_pld), .in_rdy(hb_in_rdy),
    .out_vld(hb_out_vld), .out_pld(hb_out_pld), .out_src(hb_out_src), .out_rdy(hb_out_rdy), .out_cnt(hb_out_cnt));

  typedef struct packed {
    logic [NW-1:0] src;
    logic [PW-1:0] pld;
  } exp_t;

  exp_t qa[M][$];
  exp_t qb[M][$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pld(input int src, input int tag);
    return {32'hC0DE_0000 + 32'(tag), 32'(src), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic drive(input int i, input logic [1:0] hi, input logic [1:0] lo, input int tag, input bit hash);
    if (hash) begin
      hb_in_vld[i] = 1'b1;
      hb_in_addr[i*AW +: AW] = {hi, lo, 60'(tag)};
      hb_in_pld[i*PW +: PW] = mk_pld(i, tag);
    end else begin
      in_vld[i] = 1'b1;
      in_addr[i*AW +: AW] = {hi, lo, 60'(tag)};
      in_pld[i*PW +: PW] = mk_pld(i, tag);
    end
  endtask

  task automatic expect_out(input int bank, input int src, input int tag, input bit hash);
    exp_t e;
    e.src = NW'(src);
    e.pld = mk_pld(src, tag);
    if (hash) qb[bank].push_back(e);
    else qa[bank].push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the plain-select instance
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < M; j++) begin
        if (out_vld[j] && out_rdy[j]) begin
          if (qa[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_out[%0d]: got src %0d, expected no output", j, out_src[j*NW +: NW]);
          end else begin
            exp_t e;
            e = qa[j].pop_front();
            chk($sformatf("a_out_src[%0d]", j), PW'(out_src[j*NW +: NW]), PW'(e.src));
            chk($sformatf("a_out_pld[%0d]", j), out_pld[j*PW +: PW], e.pld);
          end
        end
      end
    end
  end

  // Monitor for the hashed-select instance
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < M; j++) begin
        if (hb_out_vld[j] && hb_out_rdy[j]) begin
          if (qb[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_out[%0d]: got src %0d, expected no output", j, hb_out_src[j*NW +: NW]);
          end else begin
            exp_t e;
            e = qb[j].pop_front();
            chk($sformatf("b_out_src[%0d]", j), PW'(hb_out_src[j*NW +: NW]), PW'(e.src));
            chk($sformatf("b_out_pld[%0d]", j), hb_out_pld[j*PW +: PW], e.pld);
          end
        end
      end
    end
  end

  initial begin
    int           tag[N];
    int           order[6];
    int           bp_order[4];
    logic [N-1:0] onehot;

    rst = 1'b1;
    in_vld = '0; in_addr = '0; in_pld = '0; out_rdy = '1;
    hb_in_vld = '0; hb_in_addr = '0; hb_in_pld = '0; hb_out_rdy = '0;

    // reset: a request held during reset must not be accepted
    drive(0, 2'b00, 2'b00, 99, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_rdy", PW'(in_rdy), PW'(8'h00));
      chk("rst_out_vld", PW'(out_vld), PW'(4'h0));
      chk("rst_out_cnt", PW'(out_cnt), PW'(12'h000));
    end
    cyc();
    rst = 1'b0;
    in_vld = '0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_rdy", PW'(in_rdy), PW'(8'h00));
      chk("idle_out_vld", PW'(out_vld), PW'(4'h0));
      chk("idle_out_cnt", PW'(out_cnt), PW'(12'h000));
    end

    // single request: requester 3 to bank 2
    cyc();
    drive(3, 2'b10, 2'b00, 1, 1'b0);
    expect_out(2, 3, 1, 1'b0);
    @(negedge clk);
    chk("single_in_rdy", PW'(in_rdy), PW'(8'h08));
    chk("single_no_early_out", PW'(out_vld), PW'(4'h0));
    cyc();
    in_vld = '0;
    @(negedge clk);
    chk("single_out_vld", PW'(out_vld), PW'(4'b0100));
    chk("single_out_cnt2", PW'(out_cnt[2*CW +: CW]), PW'(3'd1));
    cyc();
    @(negedge clk);
    chk("single_drained", PW'(out_vld), PW'(4'h0));

    // round robin: requesters 0, 1, 5 all hold requests to bank 1
    cyc();
    tag[0] = 10; tag[1] = 20; tag[5] = 50;
    drive(0, 2'b01, 2'b00, tag[0], 1'b0);
    drive(1, 2'b01, 2'b00, tag[1], 1'b0);
    drive(5, 2'b01, 2'b00, tag[5], 1'b0);
    order = '{0, 1, 5, 0, 1, 5};
    for (int k = 0; k < 6; k++) begin
      expect_out(1, order[k], tag[order[k]], 1'b0);
      onehot = '0;
      onehot[order[k]] = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_in_rdy_%0d", k), PW'(in_rdy), PW'(onehot));
      cyc();
      tag[order[k]] = tag[order[k]] + 1;
      drive(order[k], 2'b01, 2'b00, tag[order[k]], 1'b0);
    end
    in_vld = '0;
    repeat (2) cyc();

    // parallel banks: requesters 2, 4, 6, 7 to banks 0..3
    drive(2, 2'b00, 2'b00, 200, 1'b0);
    drive(4, 2'b01, 2'b00, 400, 1'b0);
    drive(6, 2'b10, 2'b00, 600, 1'b0);
    drive(7, 2'b11, 2'b00, 700, 1'b0);
    expect_out(0, 2, 200, 1'b0);
    expect_out(1, 4, 400, 1'b0);
    expect_out(2, 6, 600, 1'b0);
    expect_out(3, 7, 700, 1'b0);
    @(negedge clk);
    chk("par_in_rdy", PW'(in_rdy), PW'(8'hD4));
    cyc();
    in_vld = '0;
    @(negedge clk);
    chk("par_out_vld", PW'(out_vld), PW'(4'hF));
    repeat (2) cyc();

    // backpressure: six requests to a stalled bank 0, pointer starts at 3
    out_rdy[0] = 1'b0;
    for (int i = 0; i < 6; i++) drive(i, 2'b00, 2'b00, 500 + i, 1'b0);
    bp_order = '{3, 4, 5, 0};
    for (int k = 0; k < 4; k++) begin
      expect_out(0, bp_order[k], 500 + bp_order[k], 1'b0);
      onehot = '0;
      onehot[bp_order[k]] = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_in_rdy_%0d", k), PW'(in_rdy), PW'(onehot));
      cyc();
      in_vld[bp_order[k]] = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      chk("full_in_rdy", PW'(in_rdy), PW'(8'h00));
      chk("full_cnt0", PW'(out_cnt[0 +: CW]), PW'(3'd4));
      cyc();
    end
    out_rdy[0] = 1'b1;
    expect_out(0, 1, 501, 1'b0);
    @(negedge clk);
    chk("popfull_in_rdy", PW'(in_rdy), PW'(8'h02));
    chk("popfull_cnt0_before", PW'(out_cnt[0 +: CW]), PW'(3'd4));
    cyc();
    in_vld[1] = 1'b0;
    out_rdy[0] = 1'b0;
    @(negedge clk);
    chk("popfull_cnt0_after", PW'(out_cnt[0 +: CW]), PW'(3'd4));
    chk("popfull_in_rdy_after", PW'(in_rdy), PW'(8'h00));
    cyc();
    in_vld = '0;
    out_rdy[0] = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("bp_drained_cnt", PW'(out_cnt), PW'(12'h000));

    // hashed select: addr[63:62]=01, addr[61:60]=11 -> bank 2
    cyc();
    for (int i = 0; i < 4; i++) drive(i, 2'b01, 2'b11, 900 + i, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_out(2, k, 900 + k, 1'b1);
      onehot = '0;
      onehot[k] = 1'b1;
      @(negedge clk);
      chk($sformatf("hash_in_rdy_%0d", k), PW'(hb_in_rdy), PW'(onehot));
      cyc();
      hb_in_vld[k] = 1'b0;
    end
    @(negedge clk);
    chk("hash_cnt_full", PW'(hb_out_cnt), PW'(12'h100));
    cyc();
    hb_out_rdy[2] = 1'b1;
    @(negedge clk);
    cyc();
    hb_out_rdy[2] = 1'b0;
    @(negedge clk);
    chk("hash_cnt_three", PW'(hb_out_cnt), PW'(12'h0C0));
    chk("hash_out_vld", PW'(hb_out_vld), PW'(4'b0100));

    // reset with three entries buffered in bank 2
    cyc();
    rst = 1'b1;
    drive(4, 2'b01, 2'b11, 950, 1'b1);
    @(negedge clk);
    chk("hash_rst_in_rdy", PW'(hb_in_rdy), PW'(8'h00));
    cyc();
    rst = 1'b0;
    hb_in_vld = '0;
    qb[2].delete();
    @(negedge clk);
    chk("hash_rst_out_vld", PW'(hb_out_vld), PW'(4'h0));
    chk("hash_rst_cnt", PW'(hb_out_cnt), PW'(12'h000));

    // after reset: addr[63:62]=11, addr[61:60]=11 -> bank 0
    cyc();
    hb_out_rdy = '1;
    drive(6, 2'b11, 2'b11, 1000, 1'b1);
    expect_out(0, 6, 1000, 1'b1);
    @(negedge clk);
    chk("hash_post_in_rdy", PW'(hb_in_rdy), PW'(8'h40));
    cyc();
    hb_in_vld = '0;
    repeat (3) cyc();

    @(negedge clk);
    for (int j = 0; j < M; j++) begin
      chk($sformatf("a_missing_out[%0d]", j), PW'(qa[j].size()), PW'(0));
      chk($sformatf("b_missing_out[%0d]", j), PW'(qb[j].size()), PW'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
